// File: rtl/mitm_pkg.sv
// Shared definitions for the MITM bus controller: FSM encoding, word-size
// defaults and statistics counter widths.
package mitm_pkg;

   localparam int MITM_MAX_DATA_SIZE     = 9;
   localparam int MITM_DATA_SIZE_WIDTH   = $clog2(MITM_MAX_DATA_SIZE + 1);
   localparam int STATS_WORD_COUNT_WIDTH = 16;
   localparam int STATS_OVR_COUNT_WIDTH  = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      INIT_EVAL,
      ARMED,
      CAPTURE,
      EVAL,
      WAIT_DONE
   } state_e;

endpackage

// File: rtl/mitm_bit_shifter.sv
// Per-line capture shift register, captured-bit counter and serializer index
// for one SPI data line (instantiated once for MOSI and once for MISO).
module mitm_bit_shifter
   import mitm_pkg::*;
#(
   parameter int MAX_DATA_SIZE   = MITM_MAX_DATA_SIZE,
   parameter int DATA_SIZE_WIDTH = $clog2(MAX_DATA_SIZE + 1)
) (
   input  logic                       sys_clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       capture,
   input  logic                       bit_in,
   input  logic                       advance,
   input  logic [DATA_SIZE_WIDTH-1:0] size,
   input  logic [MAX_DATA_SIZE-1:0]   fake_word,
   output logic [MAX_DATA_SIZE-1:0]   word_next,
   output logic                       full,
   output logic                       fake_bit
);

   localparam logic [DATA_SIZE_WIDTH-1:0] MAX_SIZE = DATA_SIZE_WIDTH'(MAX_DATA_SIZE);
   localparam logic [DATA_SIZE_WIDTH-1:0] ONE      = DATA_SIZE_WIDTH'(1);

   logic [MAX_DATA_SIZE-1:0]   sr_q, sr_d;
   logic [DATA_SIZE_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_SIZE_WIDTH-1:0] drv_q, drv_d;
   logic [DATA_SIZE_WIDTH-1:0] idx;

   // full looks ahead through a capture in this cycle so the word can close on its last edge
   always_comb begin
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      drv_d     = drv_q;
      word_next = capture ? {sr_q[MAX_DATA_SIZE-2:0], bit_in} : sr_q;
      full      = capture ? ((cnt_q + ONE) >= size) : (cnt_q >= size);
      if (clear) begin
         sr_d  = '0;
         cnt_d = '0;
         drv_d = '0;
      end else begin
         if (capture) begin
            sr_d = word_next;
            if (cnt_q != MAX_SIZE) begin
               cnt_d = cnt_q + ONE;
            end
         end
         if (advance && ((drv_q + ONE) < size)) begin
            drv_d = drv_q + ONE;
         end
      end
      idx      = size - ONE - drv_q;
      fake_bit = (size != '0) && (idx < MAX_SIZE) && fake_word[idx];
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
         drv_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
         drv_q <= drv_d;
      end
   end

endmodule

// File: rtl/mitm_bus_ctrl.sv
// Bus-side initiator for the MITM logic: captures SPI words, handshakes with the
// logic and drives replacement bits. Optional statistics via MITM_BUS_CTRL_STATS_EN.
module mitm_bus_ctrl
   import mitm_pkg::*;
#(
   parameter int MAX_DATA_SIZE   = MITM_MAX_DATA_SIZE,
   parameter int DATA_SIZE_WIDTH = $clog2(MAX_DATA_SIZE + 1)
) (
   input  logic                       sys_clk,
   input  logic                       rst,
   input  logic                       arm,
   input  logic                       bus_active,
   input  logic                       sample_edge,
   input  logic                       shift_edge,
   input  logic                       real_mosi_bit,
   input  logic                       real_miso_bit,
   output logic                       mitm_start,
   output logic                       eval,
   output logic [MAX_DATA_SIZE-1:0]   real_mosi_data,
   output logic [MAX_DATA_SIZE-1:0]   real_miso_data,
   input  logic                       eval_done,
   input  logic                       mitm_done,
   input  logic [DATA_SIZE_WIDTH-1:0] data_size,
   input  logic [MAX_DATA_SIZE-1:0]   fake_mosi_data,
   input  logic [MAX_DATA_SIZE-1:0]   fake_miso_data,
   input  logic                       fake_mosi_select,
   input  logic                       fake_miso_select,
   output logic                       fake_mosi_bit,
   output logic                       fake_miso_bit,
   output logic                       mosi_select,
   output logic                       miso_select,
   output logic                       overrun,
`ifdef MITM_BUS_CTRL_STATS_EN
   output logic [STATS_WORD_COUNT_WIDTH-1:0] word_count,
   output logic [STATS_OVR_COUNT_WIDTH-1:0]  ovr_count,
`endif
   output logic                       busy
);

   localparam logic [DATA_SIZE_WIDTH-1:0] MAX_SIZE = DATA_SIZE_WIDTH'(MAX_DATA_SIZE);

   state_e                     state_q, state_d;
   logic [DATA_SIZE_WIDTH-1:0] size_q, size_d, clamped_size;
   logic [MAX_DATA_SIZE-1:0]   fake_mosi_q, fake_mosi_d, fake_miso_q, fake_miso_d;
   logic                       fake_mosi_sel_q, fake_mosi_sel_d, fake_miso_sel_q, fake_miso_sel_d;
   logic [MAX_DATA_SIZE-1:0]   real_mosi_q, real_mosi_d, real_miso_q, real_miso_d;
   logic                       overrun_q, overrun_d, word_ovr_q, word_ovr_d;
   logic                       mitm_start_q, mitm_start_d, eval_q, eval_d;
   logic                       bus_active_q;
   logic                       in_word, bus_rise, abort, capture, advance, word_done;
   logic                       shifter_clear, latch_next;
   logic [MAX_DATA_SIZE-1:0]   size_mask, mosi_word, miso_word;
   logic                       mosi_full, miso_full;

   always_comb begin
      in_word       = (state_q == CAPTURE) || (state_q == EVAL);
      bus_rise      = bus_active && !bus_active_q;
      abort         = in_word && !bus_active;
      capture       = in_word && bus_active && sample_edge;
      advance       = in_word && bus_active && shift_edge;
      word_done     = (state_q == CAPTURE) && bus_active && mosi_full && miso_full;
      shifter_clear = !in_word || abort || word_done;
      clamped_size  = (data_size > MAX_SIZE) ? MAX_SIZE : data_size;
      for (int i = 0; i < MAX_DATA_SIZE; i++) begin
         size_mask[i] = (i < int'(size_q));
      end
   end

   // A shift edge seen while the logic is still evaluating means the next word's
   // first bit went out before its replacement was known, so that word runs unmodified.
   always_comb begin
      state_d         = state_q;
      size_d          = size_q;
      fake_mosi_d     = fake_mosi_q;
      fake_miso_d     = fake_miso_q;
      fake_mosi_sel_d = fake_mosi_sel_q;
      fake_miso_sel_d = fake_miso_sel_q;
      real_mosi_d     = real_mosi_q;
      real_miso_d     = real_miso_q;
      overrun_d       = overrun_q;
      word_ovr_d      = word_ovr_q;
      mitm_start_d    = 1'b0;
      eval_d          = 1'b0;
      latch_next      = 1'b0;
      case (state_q)
         IDLE: begin
            if (arm) begin
               state_d      = START;
               mitm_start_d = 1'b1;
               overrun_d    = 1'b0;
               word_ovr_d   = 1'b0;
            end
         end
         START: begin
            if (eval_done) begin
               state_d = INIT_EVAL;
               eval_d  = 1'b1;
            end
         end
         INIT_EVAL: begin
            if (eval_done) begin
               latch_next = 1'b1;
               state_d    = (clamped_size == '0) ? WAIT_DONE : ARMED;
            end
         end
         ARMED: begin
            if (bus_rise) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (abort) begin
               state_d = WAIT_DONE;
            end else if (word_done) begin
               real_mosi_d = mosi_word & size_mask;
               real_miso_d = miso_word & size_mask;
               eval_d      = 1'b1;
               word_ovr_d  = 1'b0;
               state_d     = EVAL;
            end
         end
         EVAL: begin
            if (abort) begin
               state_d = WAIT_DONE;
            end else begin
               if (advance) begin
                  overrun_d  = 1'b1;
                  word_ovr_d = 1'b1;
               end
               if (eval_done) begin
                  latch_next = 1'b1;
                  state_d    = (clamped_size == '0) ? WAIT_DONE : CAPTURE;
               end
            end
         end
         WAIT_DONE: begin
            if (mitm_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (latch_next) begin
         size_d          = clamped_size;
         fake_mosi_d     = fake_mosi_data;
         fake_miso_d     = fake_miso_data;
         fake_mosi_sel_d = fake_mosi_select;
         fake_miso_sel_d = fake_miso_select;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q         <= IDLE;
         size_q          <= '0;
         fake_mosi_q     <= '0;
         fake_miso_q     <= '0;
         fake_mosi_sel_q <= 1'b0;
         fake_miso_sel_q <= 1'b0;
         real_mosi_q     <= '0;
         real_miso_q     <= '0;
         overrun_q       <= 1'b0;
         word_ovr_q      <= 1'b0;
         mitm_start_q    <= 1'b0;
         eval_q          <= 1'b0;
         bus_active_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         size_q          <= size_d;
         fake_mosi_q     <= fake_mosi_d;
         fake_miso_q     <= fake_miso_d;
         fake_mosi_sel_q <= fake_mosi_sel_d;
         fake_miso_sel_q <= fake_miso_sel_d;
         real_mosi_q     <= real_mosi_d;
         real_miso_q     <= real_miso_d;
         overrun_q       <= overrun_d;
         word_ovr_q      <= word_ovr_d;
         mitm_start_q    <= mitm_start_d;
         eval_q          <= eval_d;
         bus_active_q    <= bus_active;
      end
   end

   mitm_bit_shifter #(
      .MAX_DATA_SIZE  (MAX_DATA_SIZE),
      .DATA_SIZE_WIDTH(DATA_SIZE_WIDTH)
   ) u_mosi_shifter (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .clear    (shifter_clear),
      .capture  (capture),
      .bit_in   (real_mosi_bit),
      .advance  (advance),
      .size     (size_q),
      .fake_word(fake_mosi_q),
      .word_next(mosi_word),
      .full     (mosi_full),
      .fake_bit (fake_mosi_bit)
   );

   mitm_bit_shifter #(
      .MAX_DATA_SIZE  (MAX_DATA_SIZE),
      .DATA_SIZE_WIDTH(DATA_SIZE_WIDTH)
   ) u_miso_shifter (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .clear    (shifter_clear),
      .capture  (capture),
      .bit_in   (real_miso_bit),
      .advance  (advance),
      .size     (size_q),
      .fake_word(fake_miso_q),
      .word_next(miso_word),
      .full     (miso_full),
      .fake_bit (fake_miso_bit)
   );

`ifdef MITM_BUS_CTRL_STATS_EN
   logic [STATS_WORD_COUNT_WIDTH-1:0] word_count_q, word_count_d;
   logic [STATS_OVR_COUNT_WIDTH-1:0]  ovr_count_q, ovr_count_d;

   // One overrun event per affected word, not per late shift edge
   always_comb begin
      word_count_d = word_count_q;
      ovr_count_d  = ovr_count_q;
      if ((state_q == IDLE) && arm) begin
         word_count_d = '0;
         ovr_count_d  = '0;
      end else begin
         if (word_done && (word_count_q != '1)) begin
            word_count_d = word_count_q + {{(STATS_WORD_COUNT_WIDTH-1){1'b0}}, 1'b1};
         end
         if ((state_q == EVAL) && advance && !word_ovr_q && (ovr_count_q != '1)) begin
            ovr_count_d = ovr_count_q + {{(STATS_OVR_COUNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         word_count_q <= '0;
         ovr_count_q  <= '0;
      end else begin
         word_count_q <= word_count_d;
         ovr_count_q  <= ovr_count_d;
      end
   end

   assign word_count = word_count_q;
   assign ovr_count  = ovr_count_q;
`endif

   assign mitm_start     = mitm_start_q;
   assign eval           = eval_q;
   assign real_mosi_data = real_mosi_q;
   assign real_miso_data = real_miso_q;
   assign overrun        = overrun_q;
   assign busy           = (state_q != IDLE);
   assign mosi_select    = fake_mosi_sel_q && (state_q == CAPTURE) && bus_active && !word_ovr_q;
   assign miso_select    = fake_miso_sel_q && (state_q == CAPTURE) && bus_active && !word_ovr_q;

endmodule

// File: tb/tb_mitm_bus_ctrl.sv
// Directed bench for mitm_bus_ctrl: a table of word records plus hand-written
// sequences for overrun, bus drop and mid-word reset.
module tb_mitm_bus_ctrl;

   typedef struct {
      logic [3:0] size_in;
      logic [3:0] len;
      logic [8:0] fake_mosi;
      logic [8:0] fake_miso;
      logic       sel_mosi;
      logic       sel_miso;
      logic       late;
      logic [8:0] mosi_bits;
      logic [8:0] miso_bits;
      logic       exp_mosi_sel;
      logic       exp_miso_sel;
   } vec_t;

   logic       sys_clk;
   logic       rst;
   logic       arm;
   logic       bus_active;
   logic       sample_edge;
   logic       shift_edge;
   logic       real_mosi_bit;
   logic       real_miso_bit;
   logic       mitm_start;
   logic       eval;
   logic [8:0] real_mosi_data;
   logic [8:0] real_miso_data;
   logic       eval_done;
   logic       mitm_done;
   logic [3:0] data_size;
   logic [8:0] fake_mosi_data;
   logic [8:0] fake_miso_data;
   logic       fake_mosi_select;
   logic       fake_miso_select;
   logic       fake_mosi_bit;
   logic       fake_miso_bit;
   logic       mosi_select;
   logic       miso_select;
   logic       overrun;
   logic       busy;
`ifdef MITM_BUS_CTRL_STATS_EN
   logic [15:0] word_count;
   logic [7:0]  ovr_count;
`endif

   int   checks = 0;
   int   fails = 0;
   int   eval_pulses = 0;
   int   eval_base;
   vec_t vecs[5];

   mitm_bus_ctrl dut (
      .sys_clk         (sys_clk),
      .rst             (rst),
      .arm             (arm),
      .bus_active      (bus_active),
      .sample_edge     (sample_edge),
      .shift_edge      (shift_edge),
      .real_mosi_bit   (real_mosi_bit),
      .real_miso_bit   (real_miso_bit),
      .mitm_start      (mitm_start),
      .eval            (eval),
      .real_mosi_data  (real_mosi_data),
      .real_miso_data  (real_miso_data),
      .eval_done       (eval_done),
      .mitm_done       (mitm_done),
      .data_size       (data_size),
      .fake_mosi_data  (fake_mosi_data),
      .fake_miso_data  (fake_miso_data),
      .fake_mosi_select(fake_mosi_select),
      .fake_miso_select(fake_miso_select),
      .fake_mosi_bit   (fake_mosi_bit),
      .fake_miso_bit   (fake_miso_bit),
      .mosi_select     (mosi_select),
      .miso_select     (miso_select),
      .overrun         (overrun),
`ifdef MITM_BUS_CTRL_STATS_EN
      .word_count      (word_count),
      .ovr_count       (ovr_count),
`endif
      .busy            (busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (eval) eval_pulses++;
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Logic's eval_done response carrying the parameters of the next word
   task automatic applyStimulus(input vec_t v);
      if (v.late) begin
         shift_edge = 1'b1;
         step();
         shift_edge = 1'b0;
         checkOutput("overrun_set", overrun, 1);
      end
      data_size        = v.size_in;
      fake_mosi_data   = v.fake_mosi;
      fake_miso_data   = v.fake_miso;
      fake_mosi_select = v.sel_mosi;
      fake_miso_select = v.sel_miso;
      eval_done        = 1'b1;
      step();
      eval_done        = 1'b0;
   endtask

   task automatic armSession(input vec_t first);
      arm = 1'b1;
      step();
      arm = 1'b0;
      checkOutput("mitm_start_pulse", mitm_start, 1);
      checkOutput("busy_after_arm", busy, 1);
      checkOutput("overrun_cleared_by_arm", overrun, 0);
      eval_done = 1'b1;
      step();
      eval_done = 1'b0;
      checkOutput("mitm_start_single", mitm_start, 0);
      checkOutput("init_eval_pulse", eval, 1);
      applyStimulus(first);
      bus_active = 1'b1;
      step();
   endtask

   task automatic runWord(input vec_t v, input int nbits);
      int n;
      n = int'(v.len);
      for (int i = 0; i < nbits; i++) begin
         checkOutput("mosi_select", mosi_select, v.exp_mosi_sel);
         checkOutput("miso_select", miso_select, v.exp_miso_sel);
         if (!v.late) begin
            checkOutput("fake_mosi_bit", fake_mosi_bit, v.fake_mosi[n-1-i]);
            checkOutput("fake_miso_bit", fake_miso_bit, v.fake_miso[n-1-i]);
         end
         real_mosi_bit = v.mosi_bits[n-1-i];
         real_miso_bit = v.miso_bits[n-1-i];
         sample_edge   = 1'b1;
         step();
         sample_edge   = 1'b0;
         if (i == n - 1) begin
            checkOutput("eval_after_last_bit", eval, 1);
            checkOutput("real_mosi_data", real_mosi_data, v.mosi_bits);
            checkOutput("real_miso_data", real_miso_data, v.miso_bits);
         end else begin
            checkOutput("eval_early", eval, 0);
            shift_edge = 1'b1;
            step();
            shift_edge = 1'b0;
         end
      end
   endtask

   task automatic endSession();
      data_size = 4'd0;
      eval_done = 1'b1;
      step();
      eval_done = 1'b0;
      checkOutput("busy_wait_done", busy, 1);
      checkOutput("mosi_select_wait_done", mosi_select, 0);
      checkOutput("miso_select_wait_done", miso_select, 0);
      mitm_done = 1'b1;
      step();
      mitm_done = 1'b0;
      bus_active = 1'b0;
      checkOutput("busy_idle", busy, 0);
   endtask

   initial begin
      // size_in, len, fake_mosi, fake_miso, sel_mosi, sel_miso, late, mosi_bits, miso_bits, exp sels
      vecs[0] = '{4'd3,  4'd3, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 9'h006, 9'h005, 1'b0, 1'b0};
      vecs[1] = '{4'd8,  4'd8, 9'h0C3, 9'h05A, 1'b0, 1'b1, 1'b0, 9'h03C, 9'h0D9, 1'b0, 1'b1};
      vecs[2] = '{4'd12, 4'd9, 9'h1A5, 9'h0F0, 1'b1, 1'b1, 1'b0, 9'h155, 9'h0AA, 1'b1, 1'b1};
      vecs[3] = '{4'd4,  4'd4, 9'h00A, 9'h005, 1'b1, 1'b1, 1'b1, 9'h009, 9'h006, 1'b0, 1'b0};
      vecs[4] = '{4'd4,  4'd4, 9'h005, 9'h00C, 1'b1, 1'b0, 1'b0, 9'h00E, 9'h003, 1'b1, 1'b0};

      rst = 1'b1; arm = 1'b0; bus_active = 1'b0; sample_edge = 1'b0; shift_edge = 1'b0;
      real_mosi_bit = 1'b0; real_miso_bit = 1'b0; eval_done = 1'b0; mitm_done = 1'b0;
      data_size = 4'd0; fake_mosi_data = 9'h0; fake_miso_data = 9'h0;
      fake_mosi_select = 1'b0; fake_miso_select = 1'b0;
      step();
      step();
      rst = 1'b0;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_eval", eval, 0);
      checkOutput("reset_mitm_start", mitm_start, 0);
      checkOutput("reset_real_mosi", real_mosi_data, 0);
      checkOutput("reset_overrun", overrun, 0);

      $display("[TB] session 1: table-driven words");
      armSession(vecs[0]);
      for (int k = 0; k < 5; k++) begin
         eval_base = eval_pulses;
         runWord(vecs[k], int'(vecs[k].len));
         if (k < 4) applyStimulus(vecs[k+1]);
         else endSession();
         checkOutput("one_eval_per_word", eval_pulses - eval_base, 1);
      end
      checkOutput("overrun_sticky", overrun, 1);

      $display("[TB] session 2: bus drop mid-word");
      armSession(vecs[1]);
      eval_base = eval_pulses;
      runWord(vecs[1], 4);
      bus_active = 1'b0;
      step();
      checkOutput("drop_miso_select", miso_select, 0);
      checkOutput("drop_busy", busy, 1);
      step();
      checkOutput("drop_no_eval", eval_pulses - eval_base, 0);
      checkOutput("drop_real_mosi_held", real_mosi_data, 9'h00E);
      arm = 1'b1;
      step();
      arm = 1'b0;
      checkOutput("arm_ignored_start", mitm_start, 0);
      checkOutput("arm_ignored_busy", busy, 1);
      mitm_done = 1'b1;
      step();
      mitm_done = 1'b0;
      checkOutput("drop_idle_busy", busy, 0);

      $display("[TB] session 3: reset mid-capture");
      armSession(vecs[1]);
      runWord(vecs[1], 2);
      rst = 1'b1;
      bus_active = 1'b0;
      step();
      rst = 1'b0;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_eval", eval, 0);
      checkOutput("midrst_real_mosi", real_mosi_data, 0);
      checkOutput("midrst_real_miso", real_miso_data, 0);
      checkOutput("midrst_miso_select", miso_select, 0);
      checkOutput("midrst_fake_mosi_bit", fake_mosi_bit, 0);
      checkOutput("midrst_fake_miso_bit", fake_miso_bit, 0);
      armSession(vecs[0]);
      runWord(vecs[0], 3);
      endSession();

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mitm_bus_ctrl.md
Name: mitm_bus_ctrl

Overview:
- Bus-side initiator/driver paired with the MITM logic block.
- Deserializes sampled SPI MOSI/MISO bits into words of the length the logic requests.
- Issues mitm_start and eval pulses to the logic and waits for eval_done / mitm_done.
- Latches the returned fake words and selects, then serializes the fake bits onto the bus. Sits between the SPI edge detector/synchronizer and the MITM logic.

Parameters:
MAX_DATA_SIZE, 9, widest word in bits; must match the MITM logic.
DATA_SIZE_WIDTH, $clog2(MAX_DATA_SIZE+1), width of data_size.

Ports:
sys_clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
arm  in  1  one-cycle pulse: begin a MITM session
bus_active  in  1  synchronized chip-select asserted
sample_edge  in  1  one-cycle pulse at SCLK sampling edge
shift_edge  in  1  one-cycle pulse at SCLK drive edge
real_mosi_bit / real_miso_bit  in  1  synchronized bus bits
mitm_start  out  1  one-cycle start pulse to logic
eval  out  1  one-cycle evaluate pulse to logic
real_mosi_data / real_miso_data  out  MAX_DATA_SIZE  last captured word, zero-extended
eval_done / mitm_done  in  1  logic handshakes
data_size  in  DATA_SIZE_WIDTH  next word length from logic
fake_mosi_data / fake_miso_data  in  MAX_DATA_SIZE  replacement words
fake_mosi_select / fake_miso_select  in  1  replace enable per line
fake_mosi_bit / fake_miso_bit  out  1  current replacement bit
mosi_select / miso_select  out  1  mux control: 1 = drive fake bit
overrun  out  1  sticky: logic too slow for the bus
busy  out  1  state != IDLE

Behaviour:
- Reset values: every output 0; all shift registers and counters 0; state IDLE.
- States: IDLE, START, INIT_EVAL, ARMED, CAPTURE, EVAL, WAIT_DONE.
- Transitions:
  - IDLE: arm -> START; pulse mitm_start for 1 cycle.
  - START: eval_done -> INIT_EVAL; pulse eval.
  - INIT_EVAL: eval_done -> latch data_size, fake words and selects; ARMED.
  - ARMED: bus_active rising -> CAPTURE.
  - CAPTURE: each sample_edge shifts bits in, MSB first: sr <= {sr[MAX-2:0], bit}. Capture bit_cnt increments.
    - When bit_cnt reaches latched size, the cycle after that sample_edge: load real_*_data from shift registers, pulse eval, clear shift regs and counters, enter EVAL.
  - EVAL: sample_edge keeps capturing into the next word. eval_done -> latch new size, fakes and selects; CAPTURE.
    - shift_edge while in EVAL: set overrun, force both selects 0 for the rest of that word.
- Drive path:
  - fake_x_bit = latched_fake_x[size-1-drv_cnt].
  - drv_cnt increments on shift_edge and saturates at size-1.
  - x_select = latched select && state==CAPTURE && bus_active && !overrun-for-word.
- Word-length rules:
  - Latched size 0: end of transaction; selects 0, bits ignored; go to WAIT_DONE.
  - Size > MAX_DATA_SIZE: clamp to MAX_DATA_SIZE.
- bus_active falls in CAPTURE/EVAL: discard the partial word, no eval; selects 0 next cycle; WAIT_DONE.
- WAIT_DONE: mitm_done -> IDLE. arm is ignored when not in IDLE.
- Simultaneous sample_edge and word completion in EVAL: capture the bit; completion is checked only in CAPTURE.
- real_*_data is held stable between eval pulses.
- overrun clears only on rst or on arm.

Optional Feature:
MITM_BUS_CTRL_STATS_EN:
- When defined, adds output word_count (16 bits) and ovr_count (8 bits).
- word_count increments per completed word; ovr_count increments per overrun event. Both saturate and clear on rst or arm.
- When undefined, neither port nor the counters exist.

Decomposition:
- Shared package mitm_pkg holds:
  - state enum encoding;
  - MAX_DATA_SIZE default and DATA_SIZE_WIDTH;
  - STATS counter widths.
- One natural sub-module, mitm_bit_shifter, instantiated twice (MOSI, MISO). It holds the capture shift register, bit counter and serializer index.

Test Plan:
- Reset mid-CAPTURE (after 2 bits) -> all outputs 0, state IDLE, and the next arm restarts cleanly.
- arm; logic returns size=3 with selects 0; bits 1,1,0 on MOSI -> real_mosi_data=9'h006 with exactly one eval pulse the cycle after the third sample_edge; both selects 0 throughout.
- Next size=8, fake_miso_data=8'h5A, fake_miso_select=1 -> miso_select=1 and fake_miso_bit sequence 0,1,0,1,1,0,1,0 across shift_edges. Real MISO bits 8'hD9 are captured as real_miso_data=9'h0D9.
- Delay eval_done until after the first shift_edge -> overrun=1 and selects 0 for that word; the following word substitutes normally.
- Drop bus_active after 4 of 8 bits -> no eval issued, selects 0 next cycle; mitm_done -> IDLE, busy=0.
- data_size=12 returned -> clamped to 9; eval after 9 bits.
